fifo_rr_drain_arbiter: RTL
==========================

Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that shares one downstream write channel (the input FIFO of the next router stage) between N upstream circ_fifo instances.
- Drives each FIFO's rd_en, absorbs the FIFO's 1-cycle registered read latency, and forwards flits as wr_en/data to the downstream FIFO.
- Never reads an empty FIFO and never writes a full destination.
- Sits at a router output port, between the per-input FIFOs and the link.

Parameters:
N_PORTS, 4, number of upstream FIFOs (2..8)
DATA_W, 8, flit width
MAX_BURST, 4, max consecutive flits granted to one port before forced rotation (>=1)
PORT_W, $clog2(N_PORTS), source-index width (derived localparam)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fifo_empty_i  in  N_PORTS  empty_o of each upstream FIFO
fifo_data_i  in  N_PORTS*DATA_W  data_o of each upstream FIFO; port k at [k*DATA_W +: DATA_W]
fifo_rd_en_o  out  N_PORTS  one-hot read strobe to the upstream FIFOs
dst_full_i  in  1  full_o of the downstream FIFO
wr_en_o  out  1  write strobe to the downstream FIFO
data_o  out  DATA_W  flit to the downstream FIFO
src_id_o  out  PORT_W  index of the port that data_o came from
busy_o  out  1  a flit is in flight or held in the skid register

Behaviour:
- Clock and reset: single clock clk_i. rst_ni is asynchronous, active-low.
- Reset values: fifo_rd_en_o=0, wr_en_o=0, data_o=0, src_id_o=0, busy_o=0.
- Reset internal state: last-granted pointer cur=N_PORTS-1 (so port 0 wins first), burst_cnt=0, flight_v=0, skid_v=0.
- Issue condition (combinational): issue = !dst_full_i && !skid_v && |(~fifo_empty_i).
  - Port selection: if burst_cnt!=0 && !fifo_empty_i[cur], select cur (burst lock).
  - Otherwise select the first non-empty port in the order cur+1, cur+2, ..., wrapping modulo N_PORTS.
- On issue:
  - fifo_rd_en_o = onehot(sel) for exactly that cycle; cur<=sel.
  - flight_v<=1 and flight_id<=sel; otherwise flight_v<=0.
- Burst counter:
  - On issue with sel==cur and burst_cnt<MAX_BURST-1: burst_cnt<=burst_cnt+1.
  - On issue with a new sel: burst_cnt<=1, or 0 if MAX_BURST==1.
  - On issue with burst_cnt==MAX_BURST-1: burst_cnt<=0, forcing rotation.
  - No issue: burst_cnt holds.
- Latency: FIFO data is valid the cycle after rd_en. A flight cycle takes fifo_data_i[flight_id].
  - If !dst_full_i: wr_en_o=1, data_o=that flit, src_id_o=flight_id, all in the same cycle (combinational).
  - If dst_full_i=1: capture the flit into the skid register (skid_v<=1, skid_data, skid_id) and hold wr_en_o=0.
- Skid drain: while skid_v=1, data_o/src_id_o show the skid contents and wr_en_o=!dst_full_i. skid_v clears on the cycle it is written out.
- No issue while skid_v=1. flight_v and skid_v are never both 1; the bench asserts this.
- Throughput: one flit per cycle with dst never full, including back-to-back reads from the same port.
- Idle outputs: when neither flight nor skid is valid, wr_en_o=0. data_o and src_id_o are don't-care (the implementation drives 0).
- busy_o = flight_v | skid_v.
- Boundaries:
  - Never assert fifo_rd_en_o[k] while fifo_empty_i[k]=1, so no upstream underflow.
  - Never assert wr_en_o while dst_full_i=1, so no downstream overflow.
  - A FIFO holding one entry is read once; its empty_o rises the next cycle and it is skipped.
  - Reset mid-transfer discards any flight or skid flit; the upstream FIFO pointer has already advanced (accepted flit loss on reset).
- Fairness: with all ports non-empty, each port gets exactly MAX_BURST consecutive grants per round.

Test Plan:
- Reset: rst_ni=0 with random inputs -> all outputs 0. First issue after release with all four FIFOs non-empty selects port 0.
- Fairness: N=4, MAX_BURST=2, every FIFO holds 4 flits (port k flits 8'hk0..8'hk3), dst never full -> rd_en order 0,0,1,1,2,2,3,3,0,0,...; wr_en_o contiguous for 16 cycles; data_o 00,01,10,11,20,21,30,31,02,...
- Skip empties: only ports 1 and 3 non-empty (1 flit each) -> reads port 1 then port 3. Port 3's data appears 1 cycle after its rd_en. No rd_en to ports 0/2.
- Backpressure: dst_full_i rises the cycle after an issue of 8'hA5 -> flit held in skid, wr_en_o=0, no new rd_en. dst_full_i falls -> wr_en_o=1 with 8'hA5 that cycle, issue resumes next cycle. No flit lost or duplicated.
- Burst break: MAX_BURST=1, port 2 holds 3 flits, port 0 holds 1 -> order 0,2,2,2 when starting at cur=3; with port 0 refilled mid-run -> 0,2,0,2,2.
- Async reset mid-stream: rst_ni pulses low during a skid hold -> wr_en_o and busy_o drop immediately. After release, arbitration restarts at port 0.

Source files
------------

// File: rtl/fifo_rr_drain_arbiter_if.sv
// fifo_rr_drain_arbiter_if: upstream FIFO read side and downstream FIFO write side of the drain arbiter
interface fifo_rr_drain_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W = 8,
  parameter int PORT_W = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0] fifo_empty_i;
  logic [N_PORTS*DATA_W-1:0] fifo_data_i;
  logic [N_PORTS-1:0] fifo_rd_en_o;
  logic dst_full_i;
  logic wr_en_o;
  logic [DATA_W-1:0] data_o;
  logic [PORT_W-1:0] src_id_o;
  logic busy_o;
  modport master (
    input fifo_empty_i, fifo_data_i, dst_full_i,
    output fifo_rd_en_o, wr_en_o, data_o, src_id_o, busy_o
  );
  modport slave (
    output fifo_empty_i, fifo_data_i, dst_full_i,
    input fifo_rd_en_o, wr_en_o, data_o, src_id_o, busy_o
  );
endinterface

// File: rtl/fifo_rr_drain_arbiter.sv
// fifo_rr_drain_arbiter: round-robin drain of N upstream FIFOs into one downstream FIFO,
// absorbing the one-cycle FIFO read latency with a single-entry skid register.
module fifo_rr_drain_arbiter #(
  parameter int N_PORTS = 4,
  parameter int DATA_W = 8,
  parameter int MAX_BURST = 4
) (
  input logic clk_i,
  input logic rst_ni,
  fifo_rr_drain_arbiter_if.master bus
);
  localparam int PORT_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  logic [PORT_W-1:0] cur, sel, idx, flight_id, skid_id;
  logic [CNT_W-1:0] burst_cnt;
  logic flight_v, skid_v, issue, found;
  logic [DATA_W-1:0] skid_data, flight_data;
  always_comb begin
    sel = cur;
    idx = cur;
    found = burst_cnt != '0 && !bus.fifo_empty_i[cur];
    for (int i = 1; i <= N_PORTS; i++) begin
      idx = PORT_W'((int'(cur) + i) % N_PORTS);
      if (!found && !bus.fifo_empty_i[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  // rst_ni gates issue so the read strobes stay low while reset is held
  assign issue = rst_ni && !bus.dst_full_i && !skid_v && |(~bus.fifo_empty_i);
  assign bus.fifo_rd_en_o = issue ? N_PORTS'(1) << sel : '0;
  assign bus.busy_o = flight_v | skid_v;
  always_comb begin
    flight_data = bus.fifo_data_i[flight_id*DATA_W +: DATA_W];
    bus.wr_en_o = (skid_v || flight_v) && !bus.dst_full_i;
    bus.data_o = skid_v ? skid_data : flight_v ? flight_data : '0;
    bus.src_id_o = skid_v ? skid_id : flight_v ? flight_id : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur <= PORT_W'(N_PORTS - 1);
      burst_cnt <= '0;
      flight_v <= 1'b0;
      flight_id <= '0;
      skid_v <= 1'b0;
      skid_data <= '0;
      skid_id <= '0;
    end else begin
      flight_v <= issue;
      if (issue) begin
        cur <= sel;
        flight_id <= sel;
        burst_cnt <= sel != cur ? CNT_W'(MAX_BURST > 1) :
                     burst_cnt == CNT_W'(MAX_BURST - 1) ? '0 : burst_cnt + 1'b1;
      end
      if (flight_v && bus.dst_full_i) begin
        skid_v <= 1'b1;
        skid_data <= flight_data;
        skid_id <= flight_id;
      end else if (skid_v && !bus.dst_full_i) skid_v <= 1'b0;
    end
  end
endmodule
